// File: rtl/tremolo_lfo_ctrl.sv
// Tremolo LFO controller: a triangle-wave gain generator stepped by audio samples.
//
// The volume ramps from 0 up to the configured depth and back down in fixed increments.
// Each step happens after (rate + 1) sample_valid strobes. Configuration is written into
// shadow registers at any time. It only becomes active while idle or when the ramp restarts
// from the bottom, so a running cycle is never distorted mid-way.
//
// Optional build macro: LFO_HOLD_EN adds HOLD_HI / HOLD_LO states. These dwell at each peak
// for (cfg_hold + 1) steps. Without the macro, the ramp reverses on the step that reaches
// a peak, and cfg_hold is ignored.
//
// Ports:
//   Clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   enable       1 runs the LFO, 0 returns to idle (unity gain)
//   sample_valid one-cycle strobe per audio sample
//   cfg_load     one-cycle strobe capturing cfg_* into the shadow registers
//   cfg_rate     samples per step minus 1
//   cfg_depth    peak volume
//   cfg_step     volume increment per step
//   cfg_hold     steps held at each peak (LFO_HOLD_EN only)
//   volume       gain word
//   vol_valid    one-cycle pulse when volume is updated
//   dir          1 = rising, 0 = falling
module tremolo_lfo_ctrl #(
  parameter int unsigned VOL_W  = 16,
  parameter int unsigned RATE_W = 12,
  parameter int unsigned HOLD_W = 8
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              sample_valid,
  input  logic              cfg_load,
  input  logic [RATE_W-1:0] cfg_rate,
  input  logic [VOL_W-1:0]  cfg_depth,
  input  logic [7:0]        cfg_step,
  input  logic [HOLD_W-1:0] cfg_hold,
  output logic [VOL_W-1:0]  volume,
  output logic              vol_valid,
  output logic              dir
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRise   = 3'd1,
    StFall   = 3'd2
`ifdef LFO_HOLD_EN
    ,
    StHoldHi = 3'd3,
    StHoldLo = 3'd4
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [VOL_W-1:0]    vol_q, vol_d;
  logic                vol_valid_q, vol_valid_d;
  logic [RATE_W-1:0]   presc_q, presc_d;

  logic [RATE_W-1:0]   sh_rate_q, sh_rate_d;
  logic [VOL_W-1:0]    sh_depth_q, sh_depth_d;
  logic [7:0]          sh_step_q, sh_step_d;
  logic [RATE_W-1:0]   act_rate_q, act_rate_d;
  logic [VOL_W-1:0]    act_depth_q, act_depth_d;
  logic [7:0]          act_step_q, act_step_d;

`ifdef LFO_HOLD_EN
  logic [HOLD_W-1:0]   sh_hold_q, sh_hold_d;
  logic [HOLD_W-1:0]   act_hold_q, act_hold_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
`else
  logic                unused_cfg_hold;
  assign unused_cfg_hold = ^cfg_hold;
`endif

  logic                step_fire;
  logic                load_act;
  logic [VOL_W:0]      step_ext;
  logic [VOL_W:0]      rise_sum;

  // Prescaler: counts samples, fires a step when the count has reached the active rate.
  assign step_fire = sample_valid && (presc_q == act_rate_q);

  always_comb begin
    presc_d = presc_q;
    if (state_q == StIdle) begin
      presc_d = '0;
    end else if (sample_valid) begin
      presc_d = step_fire ? '0 : presc_q + RATE_W'(1);
    end
  end

  // Shadow registers capture on cfg_load regardless of state.
  always_comb begin
    sh_rate_d  = sh_rate_q;
    sh_depth_d = sh_depth_q;
    sh_step_d  = sh_step_q;
`ifdef LFO_HOLD_EN
    sh_hold_d  = sh_hold_q;
`endif
    if (cfg_load) begin
      sh_rate_d  = cfg_rate;
      sh_depth_d = cfg_depth;
      sh_step_d  = cfg_step;
`ifdef LFO_HOLD_EN
      sh_hold_d  = cfg_hold;
`endif
    end
  end

  // Sum is one bit wider so the clamp against depth sees a carry out of VOL_W bits.
  assign step_ext = (VOL_W + 1)'(act_step_q);
  assign rise_sum = {1'b0, vol_q} + step_ext;

  always_comb begin
    state_d     = state_q;
    vol_d       = vol_q;
    vol_valid_d = 1'b0;
    load_act    = 1'b0;
`ifdef LFO_HOLD_EN
    hold_cnt_d  = hold_cnt_q;
`endif
    if (!enable) begin
      state_d     = StIdle;
      vol_d       = '1;
      vol_valid_d = (state_q != StIdle);
      load_act    = 1'b1;
`ifdef LFO_HOLD_EN
      hold_cnt_d  = '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d     = StRise;
          vol_d       = '0;
          vol_valid_d = 1'b1;
          load_act    = 1'b1;
        end
        StRise: begin
          if (step_fire) begin
            vol_valid_d = 1'b1;
            if (rise_sum >= {1'b0, act_depth_q}) begin
              vol_d   = act_depth_q;
`ifdef LFO_HOLD_EN
              state_d    = StHoldHi;
              hold_cnt_d = '0;
`else
              state_d = StFall;
`endif
            end else begin
              vol_d = rise_sum[VOL_W-1:0];
            end
          end
        end
        StFall: begin
          if (step_fire) begin
            vol_valid_d = 1'b1;
            if ({1'b0, vol_q} <= step_ext) begin
              vol_d = '0;
`ifdef LFO_HOLD_EN
              state_d    = StHoldLo;
              hold_cnt_d = '0;
`else
              // Bottom of the wave: the only point a running LFO picks up new config.
              state_d  = StRise;
              load_act = 1'b1;
`endif
            end else begin
              vol_d = vol_q - step_ext[VOL_W-1:0];
            end
          end
        end
`ifdef LFO_HOLD_EN
        StHoldHi: begin
          if (step_fire) begin
            if (hold_cnt_q == act_hold_q) begin
              state_d    = StFall;
              hold_cnt_d = '0;
            end else begin
              hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
          end
        end
        StHoldLo: begin
          if (step_fire) begin
            if (hold_cnt_q == act_hold_q) begin
              state_d    = StRise;
              hold_cnt_d = '0;
              load_act   = 1'b1;
            end else begin
              hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
          end
        end
`endif
        default: begin
          state_d = StIdle;
          vol_d   = '1;
        end
      endcase
    end
  end

  // Active config follows the shadow values as they were before this edge, so a cfg_load
  // coinciding with a restart waits for the next bottom.
  always_comb begin
    act_rate_d  = act_rate_q;
    act_depth_d = act_depth_q;
    act_step_d  = act_step_q;
`ifdef LFO_HOLD_EN
    act_hold_d  = act_hold_q;
`endif
    if (load_act) begin
      act_rate_d  = sh_rate_q;
      act_depth_d = sh_depth_q;
      act_step_d  = sh_step_q;
`ifdef LFO_HOLD_EN
      act_hold_d  = sh_hold_q;
`endif
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      vol_q       <= '1;
      vol_valid_q <= 1'b0;
      presc_q     <= '0;
      sh_rate_q   <= '0;
      sh_depth_q  <= '1;
      sh_step_q   <= 8'd1;
      act_rate_q  <= '0;
      act_depth_q <= '1;
      act_step_q  <= 8'd1;
`ifdef LFO_HOLD_EN
      sh_hold_q   <= '0;
      act_hold_q  <= '0;
      hold_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      vol_q       <= vol_d;
      vol_valid_q <= vol_valid_d;
      presc_q     <= presc_d;
      sh_rate_q   <= sh_rate_d;
      sh_depth_q  <= sh_depth_d;
      sh_step_q   <= sh_step_d;
      act_rate_q  <= act_rate_d;
      act_depth_q <= act_depth_d;
      act_step_q  <= act_step_d;
`ifdef LFO_HOLD_EN
      sh_hold_q   <= sh_hold_d;
      act_hold_q  <= act_hold_d;
      hold_cnt_q  <= hold_cnt_d;
`endif
    end
  end

  assign volume    = vol_q;
  assign vol_valid = vol_valid_q;
`ifdef LFO_HOLD_EN
  assign dir       = !((state_q == StFall) || (state_q == StHoldHi));
`else
  assign dir       = (state_q != StFall);
`endif

endmodule

// File: tb/tb_tremolo_lfo_ctrl.sv
// Scoreboard bench for tremolo_lfo_ctrl: stimulus pushes expected {volume, dir} pairs,
// a negedge monitor pops one per vol_valid pulse and compares.
module tb_tremolo_lfo_ctrl;
  localparam int unsigned VOL_W  = 16;
  localparam int unsigned RATE_W = 12;
  localparam int unsigned HOLD_W = 8;

  logic              Clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              sample_valid;
  logic              cfg_load;
  logic [RATE_W-1:0] cfg_rate;
  logic [VOL_W-1:0]  cfg_depth;
  logic [7:0]        cfg_step;
  logic [HOLD_W-1:0] cfg_hold;
  logic [VOL_W-1:0]  volume;
  logic              vol_valid;
  logic              dir;

  typedef struct packed {
    logic [VOL_W-1:0] vol;
    logic             dir;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cur_hold = 0;

  tremolo_lfo_ctrl #(
    .VOL_W (VOL_W),
    .RATE_W(RATE_W),
    .HOLD_W(HOLD_W)
  ) dut (
    .Clk         (Clk),
    .reset       (reset),
    .enable      (enable),
    .sample_valid(sample_valid),
    .cfg_load    (cfg_load),
    .cfg_rate    (cfg_rate),
    .cfg_depth   (cfg_depth),
    .cfg_step    (cfg_step),
    .cfg_hold    (cfg_hold),
    .volume      (volume),
    .vol_valid   (vol_valid),
    .dir         (dir)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: one expected entry per vol_valid pulse.
  always @(negedge Clk) begin : mon
    exp_t e;
    if (reset === 1'b1 && vol_valid !== 1'b0) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_vol_valid: got volume %0h, required no pulse", volume);
      end else begin
        e = exp_q.pop_front();
        check("sb_volume", 32'(volume), 32'(e.vol));
        check("sb_dir", 32'(dir), 32'(e.dir));
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic [VOL_W-1:0] v, input logic d);
    exp_t e;
    e.vol = v;
    e.dir = d;
    exp_q.push_back(e);
  endtask

  // One sample strobe followed by an idle cycle.
  task automatic smp();
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    tick();
  endtask

  task automatic exp_step(input logic [VOL_W-1:0] v, input logic d);
    push(v, d);
    smp();
  endtask

  // Dwell samples at a peak; none when the hold states are not built.
  task automatic peak_hold();
`ifdef LFO_HOLD_EN
    for (int i = 0; i <= int'(cur_hold); i++) smp();
`endif
  endtask

  task automatic cfg(input int r, input int dpt, input int s, input int h);
    cfg_rate  = RATE_W'(r);
    cfg_depth = VOL_W'(dpt);
    cfg_step  = 8'(s);
    cfg_hold  = HOLD_W'(h);
    cur_hold  = h;
    cfg_load  = 1'b1;
    tick();
    cfg_load  = 1'b0;
  endtask

  task automatic start();
    push('0, 1'b1);
    enable = 1'b1;
    tick();
    tick();
  endtask

  task automatic stop();
    push('1, 1'b1);
    enable = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; enable = 1'b0; sample_valid = 1'b0; cfg_load = 1'b0;
    cfg_rate = '0; cfg_depth = '0; cfg_step = '0; cfg_hold = '0;
    tick();
    tick();
    check("rst_volume", 32'(volume), 32'hFFFF);
    check("rst_vol_valid", 32'(vol_valid), 32'd0);
    check("rst_dir", 32'(dir), 32'd1);
    reset = 1'b1;
    tick();

    // Basic triangle: depth 4, step 1, every sample.
    cfg(0, 4, 1, 0);
    start();
    exp_step(1, 1); exp_step(2, 1); exp_step(3, 1); exp_step(4, 0);
    peak_hold();
    exp_step(3, 0); exp_step(2, 0); exp_step(1, 0); exp_step(0, 1);
    peak_hold();
    exp_step(1, 1);
    stop();

    // Prescaler: rate 3 steps on every 4th sample.
    cfg(3, 4, 1, 0);
    start();
    smp(); smp(); smp();
    check("presc_vol_frozen", 32'(volume), 32'd0);
    exp_step(1, 1);
    smp(); smp(); smp();
    exp_step(2, 1);
    stop();

    // Clamp at depth and no wrap at zero.
    cfg(0, 10, 4, 0);
    start();
    exp_step(4, 1); exp_step(8, 1); exp_step(10, 0);
    peak_hold();
    exp_step(6, 0); exp_step(2, 0); exp_step(0, 1);
    stop();

    // Config change mid-ramp applies after the next bottom.
    cfg(0, 4, 1, 0);
    start();
    exp_step(1, 1); exp_step(2, 1);
    cfg(0, 2, 1, 0);
    exp_step(3, 1); exp_step(4, 0);
    peak_hold();
    exp_step(3, 0); exp_step(2, 0); exp_step(1, 0); exp_step(0, 1);
    peak_hold();
    exp_step(1, 1); exp_step(2, 0);
    peak_hold();
    exp_step(1, 0); exp_step(0, 1);
    stop();

    // depth 0: volume pinned at 0, direction flips every step.
    cfg(0, 0, 1, 0);
    start();
    exp_step(0, 0);
    peak_hold();
    exp_step(0, 1);
    peak_hold();
    exp_step(0, 0);
    stop();

    // step 0: volume frozen, steps still reported.
    cfg(0, 4, 0, 0);
    start();
    exp_step(0, 1); exp_step(0, 1); exp_step(0, 1);
    stop();

    // Drop enable at 3, then asynchronous reset mid-ramp.
    cfg(0, 4, 1, 0);
    start();
    exp_step(1, 1); exp_step(2, 1); exp_step(3, 1);
    stop();
    check("idle_volume", 32'(volume), 32'hFFFF);
    check("idle_dir", 32'(dir), 32'd1);
    start();
    exp_step(1, 1); exp_step(2, 1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_volume", 32'(volume), 32'hFFFF);
    check("async_rst_vol_valid", 32'(vol_valid), 32'd0);
    check("async_rst_dir", 32'(dir), 32'd1);
    tick();
    push('0, 1'b1);
    reset = 1'b1;
    tick();
    tick();
    // Reset config: depth all-ones, step 1, rate 0.
    exp_step(1, 1); exp_step(2, 1);
    stop();
    tick();
    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
